// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] result;

    modport master (output start, op, src_a, src_b, flush, input busy, done, result);
    modport slave  (input start, op, src_a, src_b, flush, output busy, done, result);
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing {HI,LO} with a one-cycle done strobe.
// Multiply takes 2 cycles; divide is a 32-step restoring divider plus a sign-fix cycle.
module hilo_muldiv (
    input  logic           clk,
    input  logic           rst,
    hilo_muldiv_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [4:0]  cnt;
    logic        q_neg;
    logic        r_neg;
    logic        div0;
    logic        busy;
    logic        done;
    logic [63:0] result;

    logic        ext_a;
    logic        ext_b;
    logic [63:0] prod;
    logic [32:0] sh;
    logic        ge;
    logic [31:0] diff;
    logic        sgn_div;
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    // Only MULT sign-extends; MULTU zero-extends, then one 64-bit multiply covers both.
    assign ext_a = (op_q == 2'b00) & a_q[31];
    assign ext_b = (op_q == 2'b00) & b_q[31];
    assign prod  = {{32{ext_a}}, a_q} * {{32{ext_b}}, b_q};

    // Shifted remainder can reach 33 bits, but whenever it is >= divisor the difference fits in 32.
    assign sh   = {rem, quo[31]};
    assign ge   = sh >= {1'b0, dvs};
    assign diff = sh[31:0] - dvs;

    assign sgn_div = (bus.op == 2'b10);
    assign a_abs   = (sgn_div && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    assign b_abs   = (sgn_div && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= 2'b00;
            a_q    <= '0;
            b_q    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        a_q  <= bus.src_a;
                        b_q  <= bus.src_b;
                        busy <= 1'b1;
                        if (!bus.op[1]) begin
                            state <= MUL;
                        end else begin
                            state <= DIV;
                            cnt   <= '0;
                            rem   <= '0;
                            quo   <= a_abs;
                            dvs   <= b_abs;
                            div0  <= (bus.src_b == 32'd0);
                            q_neg <= sgn_div & (bus.src_a[31] ^ bus.src_b[31]);
                            r_neg <= sgn_div & bus.src_a[31];
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    result <= prod;
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                DIV: begin
                    rem <= ge ? diff : sh[31:0];
                    quo <= {quo[30:0], ge};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (div0)
                        result <= {a_q, 32'hFFFF_FFFF};
                    else
                        result <= {r_neg ? (32'd0 - rem) : rem, q_neg ? (32'd0 - quo) : quo};
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
endmodule
